// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
// Grant encoding names which writer owns the single write port in a cycle.
package regfile_wb_arbiter_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
   localparam int REG_ZERO   = 0;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_PIPE = 2'd1,
      GNT_MC   = 2'd2
   } gnt_e;

   // Pointer width that stays legal for a single-entry buffer.
   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of the writeback, multi-cycle, decode-check and register-file write signals.
// The slave side is the arbiter; the master side is everything around it.
interface regfile_wb_arbiter_if
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
);

   logic              pipe_wreg;
   logic [ADDR_W-1:0] pipe_dest;
   logic [DATA_W-1:0] pipe_data;
   logic              pipe_hold;

   logic              mc_valid;
   logic              mc_ready;
   logic [ADDR_W-1:0] mc_dest;
   logic [DATA_W-1:0] mc_data;

   logic              iss_valid;
   logic [ADDR_W-1:0] iss_dest;
   logic [ADDR_W-1:0] chk_rs;
   logic [ADDR_W-1:0] chk_rt;
   logic [ADDR_W-1:0] chk_rd;
   logic              stall;

   logic              wwreg;
   logic [ADDR_W-1:0] wdestReg;
   logic [DATA_W-1:0] wbData;

   modport master (
      output pipe_wreg, pipe_dest, pipe_data,
      output mc_valid, mc_dest, mc_data,
      output iss_valid, iss_dest, chk_rs, chk_rt, chk_rd,
      input  pipe_hold, mc_ready, stall,
      input  wwreg, wdestReg, wbData
   );

   modport slave (
      input  pipe_wreg, pipe_dest, pipe_data,
      input  mc_valid, mc_dest, mc_data,
      input  iss_valid, iss_dest, chk_rs, chk_rt, chk_rd,
      output pipe_hold, mc_ready, stall,
      output wwreg, wdestReg, wbData
   );

endinterface

// File: rtl/regfile_wb_fifo.sv
// Small circular buffer holding completed multi-cycle results until they win the write port.
// Callers must not push when full or pop when empty.
module regfile_wb_fifo
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int  DATA_W = DATA_W_DEF,
   parameter int  ADDR_W = ADDR_W_DEF,
   parameter int  DEPTH  = 2,
   localparam int PTR_W  = ptr_w(DEPTH),
   localparam int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] push_dest,
   input  logic [DATA_W-1:0] push_data,
   output logic [ADDR_W-1:0] head_dest,
   output logic [DATA_W-1:0] head_data,
   output logic [CNT_W-1:0]  count,
   output logic              full,
   output logic              empty
);

   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

   logic [ADDR_W-1:0] dest_q [DEPTH];
   logic [ADDR_W-1:0] dest_d [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DATA_W-1:0] data_d [DEPTH];
   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      dest_d  = dest_q;
      data_d  = data_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (push) begin
         dest_d[tail_q] = push_dest;
         data_d[tail_q] = push_data;
         tail_d         = next_ptr(tail_q);
      end
      if (pop) begin
         head_d = next_ptr(head_q);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         dest_q  <= '{default: '0};
         data_q  <= '{default: '0};
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         dest_q  <= dest_d;
         data_q  <= data_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign head_dest = dest_q[head_q];
   assign head_data = data_q[head_q];
   assign count     = count_q;
   assign full      = (count_q == CNT_W'(DEPTH));
   assign empty     = (count_q == '0);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Sole driver of the register-file write port: arbitrates pipeline writeback against buffered
// multi-cycle results, forces starved results through, and tracks pending destinations for decode.
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int MC_DEPTH   = 2,
   parameter int STARVE_MAX = 4
) (
   input logic                  clock,
   input logic                  reset,
   regfile_wb_arbiter_if.slave  bus
);

   localparam int NREG  = 1 << ADDR_W;
   localparam int CNT_W = $clog2(MC_DEPTH + 1);
   localparam int STV_W = $clog2(STARVE_MAX + 1);
   localparam logic [ADDR_W-1:0] ZERO_REG  = ADDR_W'(REG_ZERO);
   localparam logic [STV_W-1:0]  STV_LIMIT = STV_W'(STARVE_MAX);

   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_full;
   logic              fifo_empty;
   logic [ADDR_W-1:0] head_dest;
   logic [DATA_W-1:0] head_data;
   logic              push;
   logic              pop;
   logic              hold;
   gnt_e              gnt;

   logic [STV_W-1:0]  starve_q, starve_d;
   logic [NREG-1:0]   busy_q, busy_d;
   logic              wwreg_q, wwreg_d;
   logic [ADDR_W-1:0] wdest_q, wdest_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;

   regfile_wb_fifo #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (MC_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .push_dest (bus.mc_dest),
      .push_data (bus.mc_data),
      .head_dest (head_dest),
      .head_data (head_data),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign hold = (starve_q == STV_LIMIT) && !fifo_empty;
   assign push = bus.mc_valid && !fifo_full;
   assign pop  = (gnt == GNT_MC);

   // A held pipeline forfeits the port, so its inputs are ignored that cycle.
   always_comb begin
      gnt = GNT_NONE;
      if (hold) begin
         gnt = GNT_MC;
      end else if (bus.pipe_wreg) begin
         gnt = GNT_PIPE;
      end else if (!fifo_empty) begin
         gnt = GNT_MC;
      end
   end

   always_comb begin
      wwreg_d  = 1'b0;
      wdest_d  = wdest_q;
      wdata_d  = wdata_q;
      starve_d = starve_q;
      busy_d   = busy_q;
      case (gnt)
         GNT_PIPE: begin
            if (bus.pipe_dest != ZERO_REG) begin
               wwreg_d = 1'b1;
               wdest_d = bus.pipe_dest;
               wdata_d = bus.pipe_data;
            end
            if (!fifo_empty && (starve_q != STV_LIMIT)) begin
               starve_d = starve_q + STV_W'(1);
            end
         end
         GNT_MC: begin
            if (head_dest != ZERO_REG) begin
               wwreg_d = 1'b1;
               wdest_d = head_dest;
               wdata_d = head_data;
               busy_d[head_dest] = 1'b0;
            end
            starve_d = '0;
         end
         default: begin
            wwreg_d = 1'b0;
         end
      endcase
      // Setting after clearing lets a same-edge issue win over a retiring result.
      if (bus.iss_valid && (bus.iss_dest != ZERO_REG)) begin
         busy_d[bus.iss_dest] = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wwreg_q  <= 1'b0;
         wdest_q  <= '0;
         wdata_q  <= '0;
         starve_q <= '0;
         busy_q   <= '0;
      end else begin
         wwreg_q  <= wwreg_d;
         wdest_q  <= wdest_d;
         wdata_q  <= wdata_d;
         starve_q <= starve_d;
         busy_q   <= busy_d;
      end
   end

   assign bus.pipe_hold = hold;
   assign bus.mc_ready  = (fifo_count < CNT_W'(MC_DEPTH));
   assign bus.stall     = busy_q[bus.chk_rs] | busy_q[bus.chk_rt] | busy_q[bus.chk_rd];
   assign bus.wwreg     = wwreg_q;
   assign bus.wdestReg  = wdest_q;
   assign bus.wbData    = wdata_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios with literal expectations, then random traffic
// compared every cycle against a queue-based reference model of the write port.
module tb_regfile_wb_arbiter;

   localparam int DATA_W     = 32;
   localparam int ADDR_W     = 5;
   localparam int MC_DEPTH   = 2;
   localparam int STARVE_MAX = 4;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;
   bit   checking = 1'b0;

   always #5 clock = ~clock;

   regfile_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   regfile_wb_arbiter #(
      .DATA_W     (DATA_W),
      .ADDR_W     (ADDR_W),
      .MC_DEPTH   (MC_DEPTH),
      .STARVE_MAX (STARVE_MAX)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [ADDR_W-1:0] dest;
      logic [DATA_W-1:0] data;
   } ent_t;

   ent_t              mq[$];
   int                m_starve = 0;
   bit                m_busy[32];
   bit                m_wwreg = 1'b0;
   logic [ADDR_W-1:0] m_wdest = '0;
   logic [DATA_W-1:0] m_wdata = '0;

   // Reference model: results wait in a queue; the write port shows what was granted last edge.
   always @(posedge clock) begin : model
      ent_t e;
      bit   can_push;
      bit   forced;
      if (reset) begin
         mq.delete();
         m_starve = 0;
         foreach (m_busy[i]) m_busy[i] = 1'b0;
         m_wwreg = 1'b0;
         m_wdest = '0;
         m_wdata = '0;
      end else begin
         can_push = (mq.size() < MC_DEPTH);
         forced   = (m_starve == STARVE_MAX) && (mq.size() > 0);
         m_wwreg  = 1'b0;
         if (forced || (!bus.pipe_wreg && mq.size() > 0)) begin
            e = mq.pop_front();
            m_starve = 0;
            if (e.dest != 0) begin
               m_wwreg = 1'b1;
               m_wdest = e.dest;
               m_wdata = e.data;
               m_busy[e.dest] = 1'b0;
            end
         end else if (bus.pipe_wreg) begin
            if (mq.size() > 0 && m_starve < STARVE_MAX) m_starve++;
            if (bus.pipe_dest != 0) begin
               m_wwreg = 1'b1;
               m_wdest = bus.pipe_dest;
               m_wdata = bus.pipe_data;
            end
         end
         if (bus.mc_valid && can_push) mq.push_back('{bus.mc_dest, bus.mc_data});
         if (bus.iss_valid && bus.iss_dest != 0) m_busy[bus.iss_dest] = 1'b1;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("[TB] FAIL %s at %0t: actual 0x%0h, required 0x%0h", name, $time, act, exp);
      end
   endtask

   // Per-cycle comparison against the model, half a cycle after the active edge.
   always @(negedge clock) begin
      if (checking) begin
         checkOutput("model_wwreg", 32'(bus.wwreg), 32'(m_wwreg));
         if (m_wwreg) begin
            checkOutput("model_wdestReg", 32'(bus.wdestReg), 32'(m_wdest));
            checkOutput("model_wbData", bus.wbData, m_wdata);
         end
         checkOutput("model_pipe_hold", 32'(bus.pipe_hold),
                     32'((m_starve == STARVE_MAX) && (mq.size() > 0)));
         checkOutput("model_mc_ready", 32'(bus.mc_ready), 32'(mq.size() < MC_DEPTH));
         checkOutput("model_stall", 32'(bus.stall),
                     32'(m_busy[bus.chk_rs] | m_busy[bus.chk_rt] | m_busy[bus.chk_rd]));
      end
   end

   task automatic applyStimulus(
      input logic pw, input logic [ADDR_W-1:0] pd, input logic [DATA_W-1:0] pdat,
      input logic mv, input logic [ADDR_W-1:0] md, input logic [DATA_W-1:0] mdat,
      input logic iv, input logic [ADDR_W-1:0] id,
      input logic [ADDR_W-1:0] rs, input logic [ADDR_W-1:0] rt, input logic [ADDR_W-1:0] rd);
      bus.pipe_wreg = pw;
      bus.pipe_dest = pd;
      bus.pipe_data = pdat;
      bus.mc_valid  = mv;
      bus.mc_dest   = md;
      bus.mc_data   = mdat;
      bus.iss_valid = iv;
      bus.iss_dest  = id;
      bus.chk_rs    = rs;
      bus.chk_rt    = rt;
      bus.chk_rd    = rd;
   endtask

   task automatic idle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   initial begin
      logic             pw, mv, iv;
      logic [ADDR_W-1:0] rs, rt, rd;
      bit               st;

      // Reset held two cycles while a result is offered.
      applyStimulus(0, 0, 0, 1, 5'd9, 32'h99, 0, 0, 5'd7, 0, 0);
      reset = 1'b1;
      tick();
      tick();
      checking = 1'b1;
      #2;
      checkOutput("rst_wwreg", 32'(bus.wwreg), 32'd0);
      checkOutput("rst_wdestReg", 32'(bus.wdestReg), 32'd0);
      checkOutput("rst_wbData", bus.wbData, 32'd0);
      checkOutput("rst_mc_ready", 32'(bus.mc_ready), 32'd1);
      checkOutput("rst_stall", 32'(bus.stall), 32'd0);
      reset = 1'b0;
      applyStimulus(1, 5'd3, 32'h20000022, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      idle();
      #2;
      checkOutput("first_wwreg", 32'(bus.wwreg), 32'd1);
      checkOutput("first_wdestReg", 32'(bus.wdestReg), 32'd3);
      checkOutput("first_wbData", bus.wbData, 32'h20000022);
      tick();

      // Contention: a pipeline write beats a freshly buffered result.
      applyStimulus(0, 0, 0, 1, 5'd5, 32'h40000044, 0, 0, 0, 0, 0);
      tick();
      applyStimulus(1, 5'd10, 32'h1010, 0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      checkOutput("cont_none_yet", 32'(bus.wwreg), 32'd0);
      tick();
      idle();
      #2;
      checkOutput("cont_pipe_wwreg", 32'(bus.wwreg), 32'd1);
      checkOutput("cont_pipe_dest", 32'(bus.wdestReg), 32'd10);
      tick();
      idle();
      #2;
      checkOutput("cont_mc_dest", 32'(bus.wdestReg), 32'd5);
      checkOutput("cont_mc_data", bus.wbData, 32'h40000044);
      tick();
      #2;
      checkOutput("cont_quiet", 32'(bus.wwreg), 32'd0);
      tick();

      // Starvation: hold on the 5th blocked cycle, then again 5 cycles after the counter clears.
      applyStimulus(1, 5'd16, 32'h1600, 1, 5'd12, 32'hABCD, 0, 0, 0, 0, 0);
      tick();
      for (int k = 1; k <= 10; k++) begin
         applyStimulus(1, 5'(16 + k), 32'(k), (k == 5), 5'd13, 32'h1313, 0, 0, 0, 0, 0);
         #2;
         checkOutput($sformatf("starve_hold_c%0d", k), 32'(bus.pipe_hold), 32'((k == 5) || (k == 10)));
         if (k == 6) begin
            checkOutput("starve_forced_dest", 32'(bus.wdestReg), 32'd12);
            checkOutput("starve_forced_data", bus.wbData, 32'hABCD);
         end
         tick();
      end
      idle();
      #2;
      checkOutput("starve_second_dest", 32'(bus.wdestReg), 32'd13);
      checkOutput("starve_second_data", bus.wbData, 32'h1313);
      tick();
      tick();

      // Full buffer drains in order once the pipeline goes quiet.
      applyStimulus(1, 5'd20, 32'h2020, 1, 5'd21, 32'h21, 0, 0, 0, 0, 0);
      tick();
      applyStimulus(1, 5'd20, 32'h2020, 1, 5'd22, 32'h22, 0, 0, 0, 0, 0);
      tick();
      idle();
      #2;
      checkOutput("full_mc_ready", 32'(bus.mc_ready), 32'd0);
      tick();
      idle();
      #2;
      checkOutput("drain1_dest", 32'(bus.wdestReg), 32'd21);
      checkOutput("drain1_ready", 32'(bus.mc_ready), 32'd1);
      tick();
      #2;
      checkOutput("drain2_wwreg", 32'(bus.wwreg), 32'd1);
      checkOutput("drain2_dest", 32'(bus.wdestReg), 32'd22);
      tick();
      #2;
      checkOutput("drain_done", 32'(bus.wwreg), 32'd0);
      tick();

      // Scoreboard: r7 stays busy until its result is granted.
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd7, 0, 0, 0);
      tick();
      idle();
      #1;
      checkOutput("sb_rs0", 32'(bus.stall), 32'd0);
      bus.chk_rs = 5'd7;
      #1;
      checkOutput("sb_rs7_busy", 32'(bus.stall), 32'd1);
      tick();
      applyStimulus(0, 0, 0, 1, 5'd7, 32'h77, 0, 0, 5'd7, 0, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 0, 0);
      #2;
      checkOutput("sb_still_busy", 32'(bus.stall), 32'd1);
      tick();
      #2;
      checkOutput("sb_cleared", 32'(bus.stall), 32'd0);
      checkOutput("sb_wdest", 32'(bus.wdestReg), 32'd7);
      checkOutput("sb_wdata", bus.wbData, 32'h77);
      tick();

      // Register 0 results are consumed without a write.
      applyStimulus(1, 5'd25, 32'h2525, 1, 5'd0, 32'hDEAD, 0, 0, 0, 0, 0);
      tick();
      applyStimulus(1, 5'd25, 32'h2525, 1, 5'd0, 32'hBEEF, 0, 0, 0, 0, 0);
      tick();
      idle();
      #2;
      checkOutput("r0_full", 32'(bus.mc_ready), 32'd0);
      tick();
      #2;
      checkOutput("r0_pop1_wwreg", 32'(bus.wwreg), 32'd0);
      checkOutput("r0_pop1_ready", 32'(bus.mc_ready), 32'd1);
      tick();
      #2;
      checkOutput("r0_pop2_wwreg", 32'(bus.wwreg), 32'd0);
      tick();

      // Random traffic with occasional mid-flight resets.
      for (int i = 0; i < 3000; i++) begin
         pw = ($urandom_range(0, 9) < 7);
         mv = ($urandom_range(0, 9) < 4);
         rs = 5'($urandom_range(0, 7));
         rt = 5'($urandom_range(0, 7));
         rd = 5'($urandom_range(0, 7));
         st = m_busy[rs] | m_busy[rt] | m_busy[rd];
         iv = !st && ($urandom_range(0, 3) == 0);
         applyStimulus(pw, 5'($urandom_range(0, 7)), $urandom, mv, 5'($urandom_range(0, 7)), $urandom,
                       iv, rd, rs, rt, rd);
         reset = ($urandom_range(0, 199) == 0);
         tick();
      end
      reset = 1'b0;
      idle();
      tick();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
